// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32IM main-memory path.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   FUNC3_LW                : access-size code used for instruction fetches
//   arb_state_e             : arbiter state encoding (IDLE, GRANT_I, GRANT_D)
package rv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Fetches are always full-word loads.
  localparam logic [2:0] FUNC3_LW = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// Ports:
//   reqs_i       [1:0] request vector, bit 0 = fetch side, bit 1 = data side
//   lastGrant_i        side served last (0 = fetch, 1 = data)
//   grant_o      [1:0] one-hot grant, zero when nothing is requested
module rr_pick2 (
  input  logic [1:0] reqs_i,
  input  logic       lastGrant_i,
  output logic [1:0] grant_o
);

  // A lone requester always wins; on a tie the side that was not served
  // last goes first so the two sides alternate under continuous load.
  always_comb begin
    grant_o = 2'b00;
    case (reqs_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = lastGrant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one main-memory port between the instruction-fetch side (I) and the
// data-access side (D). Both sides and the memory use a busywait handshake.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   i_read, i_address          fetch request and address
//   i_readdata, i_busywait     fetch data (completion cycle only) and stall
//   d_read, d_write            data load / store requests (store wins if both)
//   d_address, d_writedata     data address and store data
//   d_func3                    load/store size, forwarded to memory
//   d_readdata, d_busywait     load data (completion cycle only) and stall
//   mem_read, mem_write        memory strobes
//   mem_address, mem_writedata memory address and write data
//   mem_func3                  memory access size
//   mem_readdata, mem_busywait memory return data and busy flag
//   timeout_err                sticky flag, set when a grant is aborted
module dmem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [2:0]        d_func3,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              timeout_err
);

  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_e       state_q, state_d;
  logic             lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic             dWrite_q, dWrite_d;

  logic       iReq, dReq;
  logic       granted, complete, abort;
  logic [1:0] pick;

  assign iReq = i_read;
  assign dReq = d_read | d_write;

  assign granted  = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign complete = granted && !mem_busywait;
  // Completion takes priority over an abort landing in the same cycle.
  assign abort    = TO_EN && granted && mem_busywait && (waitCnt_q == CNT_LAST);

  rr_pick2 u_pick (
    .reqs_i      ({dReq, iReq}),
    .lastGrant_i (lastGrant_q),
    .grant_o     (pick)
  );

  // State, fairness pointer, timeout counter, error flag and the latched
  // store/load type of the current data grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lastGrant_q  <= 1'b0;
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
      dWrite_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastGrant_q  <= lastGrant_d;
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
      dWrite_q     <= dWrite_d;
    end
  end

  // Next-state logic. The strobe type is captured on grant so that a
  // requester dropping its request mid-grant does not change the access.
  always_comb begin
    state_d      = state_q;
    lastGrant_d  = lastGrant_q;
    waitCnt_d    = waitCnt_q;
    timeoutErr_d = timeoutErr_q;
    dWrite_d     = dWrite_q;
    unique case (state_q)
      IDLE: begin
        waitCnt_d = '0;
        if (pick[1]) begin
          state_d  = GRANT_D;
          dWrite_d = d_write;
        end else if (pick[0]) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (complete) begin
          state_d     = IDLE;
          lastGrant_d = (state_q == GRANT_D);
          waitCnt_d   = '0;
        end else if (abort) begin
          state_d      = IDLE;
          timeoutErr_d = 1'b1;
          waitCnt_d    = '0;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side and requester-side outputs, decoded straight from state so
  // an asynchronous reset drops the strobes without waiting for an edge.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    mem_func3     = 3'b000;
    i_readdata    = '0;
    d_readdata    = '0;
    unique case (state_q)
      GRANT_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        mem_func3   = FUNC3_LW;
        if (complete) i_readdata = mem_readdata;
      end
      GRANT_D: begin
        mem_write     = dWrite_q;
        mem_read      = !dWrite_q;
        mem_address   = d_address;
        mem_writedata = d_writedata;
        mem_func3     = d_func3;
        if (complete) d_readdata = mem_readdata;
      end
      default: ;
    endcase
  end

  // A side stalls while it requests, except in the cycle its grant ends,
  // whether by completion or by abort.
  assign i_busywait  = iReq && !((state_q == GRANT_I) && (complete || abort));
  assign d_busywait  = dReq && !((state_q == GRANT_D) && (complete || abort));
  assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter. Requesters and memory are small agents;
// expected outputs come from a transaction-level model of who owns the port.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read, d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [2:0]    d_func3;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;
  logic          timeout_err;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_func3(d_func3), .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_func3(mem_func3), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .timeout_err(timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Port ownership model: owner 0 = nobody, 1 = fetch, 2 = data.
  int mOwner, mLastServed, mCyclesHeld;
  bit mErr, mIsStore;
  bit cDone, cAbort;

  // Agent knobs and state.
  bit iPend, dPend, iDone, dDone;
  int iBudget, dBudget, iRate, dRate, busyRate, memLat, memCnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOwner = 0; mLastServed = 1; mCyclesHeld = 0; mErr = 0; mIsStore = 0;
  endtask

  // Expected outputs for the current cycle, from the ownership model.
  task automatic checkCycle();
    logic [31:0] eIRd, eDRd, eAddr, eWd;
    logic eRd, eWr, eIBusy, eDBusy;
    logic [2:0] eF3;
    logic iWants, dWants;
    iWants = i_read;
    dWants = d_read | d_write;
    eIRd = '0; eDRd = '0; eAddr = '0; eWd = '0; eRd = 0; eWr = 0; eF3 = 3'b000;
    cDone  = (mOwner != 0) && !mem_busywait;
    cAbort = (mOwner != 0) && mem_busywait && (mCyclesHeld + 1 == TO);
    if (mOwner == 1) begin
      eRd = 1; eAddr = i_address; eF3 = 3'b010;
      if (cDone) eIRd = mem_readdata;
    end else if (mOwner == 2) begin
      eWr = mIsStore; eRd = !mIsStore; eAddr = d_address; eWd = d_writedata; eF3 = d_func3;
      if (cDone) eDRd = mem_readdata;
    end
    eIBusy = iWants && !(mOwner == 1 && (cDone || cAbort));
    eDBusy = dWants && !(mOwner == 2 && (cDone || cAbort));
    checkOutput("mem_read",      32'(mem_read),      32'(eRd));
    checkOutput("mem_write",     32'(mem_write),     32'(eWr));
    checkOutput("mem_address",   mem_address,        eAddr);
    checkOutput("mem_writedata", mem_writedata,      eWd);
    checkOutput("mem_func3",     32'(mem_func3),     32'(eF3));
    checkOutput("i_busywait",    32'(i_busywait),    32'(eIBusy));
    checkOutput("d_busywait",    32'(d_busywait),    32'(eDBusy));
    checkOutput("i_readdata",    i_readdata,         eIRd);
    checkOutput("d_readdata",    d_readdata,         eDRd);
    checkOutput("timeout_err",   32'(timeout_err),   32'(mErr));
    iDone = iWants && !eIBusy;
    dDone = dWants && !eDBusy;
  endtask

  // Ownership changes at the clock edge.
  task automatic modelStep();
    bit iWants, dWants;
    iWants = i_read;
    dWants = d_read | d_write;
    if (!reset) modelReset();
    else if (mOwner == 0) begin
      if (iWants && dWants) mOwner = (mLastServed == 2) ? 1 : 2;
      else if (dWants)      mOwner = 2;
      else if (iWants)      mOwner = 1;
      if (mOwner == 2) mIsStore = d_write;
      mCyclesHeld = 0;
    end else if (cDone) begin
      mLastServed = mOwner; mOwner = 0;
    end else if (cAbort) begin
      mErr = 1; mOwner = 0;
    end else mCyclesHeld++;
  endtask

  // Drive requester and memory inputs for one cycle.
  task automatic applyStimulus();
    int op;
    if (iPend && iDone) begin iPend = 0; i_read = 0; end
    if (dPend && dDone) begin dPend = 0; d_read = 0; d_write = 0; end
    iDone = 0; dDone = 0;
    if (!iPend && iBudget > 0 && $urandom_range(99) < iRate) begin
      iPend = 1; iBudget--; i_read = 1; i_address = $urandom & 32'hFFFF_FFFC;
    end
    if (!dPend && dBudget > 0 && $urandom_range(99) < dRate) begin
      dPend = 1; dBudget--;
      op = $urandom_range(2);
      d_read = (op != 1); d_write = (op != 0);
      d_address = $urandom; d_writedata = $urandom; d_func3 = 3'($urandom_range(7));
    end
    if (mOwner != 0) begin
      if (memLat >= 0) mem_busywait = (memCnt < memLat);
      else mem_busywait = ($urandom_range(99) < busyRate);
      memCnt++;
    end else begin
      memCnt = 0;
      mem_busywait = 1'($urandom_range(1));
    end
    mem_readdata = $urandom;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      applyStimulus();
      #2;
      checkCycle();
      @(posedge clk);
      modelStep();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_writedata = '0; d_func3 = '0;
    mem_readdata = '0; mem_busywait = 1;
    iPend = 0; dPend = 0; iDone = 0; dDone = 0; memCnt = 0;
    modelReset();

    $display("[TB] reset with both sides requesting");
    iRate = 100; dRate = 100; iBudget = 1; dBudget = 1; memLat = 0; busyRate = 0;
    runCycles(3);
    #2 reset = 1;
    runCycles(8);

    $display("[TB] single data load, three busy cycles");
    iBudget = 0; dBudget = 1; memLat = 3;
    runCycles(8);

    $display("[TB] single fetch, zero-wait memory");
    iBudget = 1; memLat = 0;
    runCycles(4);

    $display("[TB] continuous contention");
    iBudget = 4; dBudget = 4; memLat = 1;
    runCycles(24);

    $display("[TB] data request during a fetch grant");
    iBudget = 1; dBudget = 0; memLat = 3;
    runCycles(2);
    dBudget = 1;
    runCycles(12);

    $display("[TB] timeout on a stuck memory");
    iBudget = 0; dBudget = 1; memLat = 100;
    runCycles(8);
    memLat = 0; iBudget = 3; dBudget = 3;
    runCycles(16);

    $display("[TB] random traffic");
    memLat = -1; busyRate = 50; iRate = 40; dRate = 40; iBudget = 100000; dBudget = 100000;
    runCycles(1500);

    $display("[TB] reset in the middle of a data grant");
    iBudget = 0; dBudget = 0; memLat = 0;
    runCycles(8);
    dBudget = 1; dRate = 100; memLat = 100;
    runCycles(2);
    @(negedge clk);
    #3 reset = 0;
    #1;
    checkOutput("rst_mem_read",    32'(mem_read),    32'd0);
    checkOutput("rst_mem_write",   32'(mem_write),   32'd0);
    checkOutput("rst_mem_address", mem_address,      32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_d_busywait",  32'(d_busywait),  32'(d_read | d_write));
    modelReset();
    @(posedge clk);
    modelStep();
    #2 reset = 1;
    memLat = 1;
    runCycles(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
